// File: rtl/arb_pkg.sv
// Purpose: shared constants, FSM encoding and helpers for the memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: NUM_REQ, IDX_W, DEFAULT_TIMEOUT_CYCLES, state_t {IDLE, OWNED}, idx2onehot().
package arb_pkg;

  localparam int NUM_REQ                = 4;
  localparam int IDX_W                  = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Purpose: combinational round-robin winner search over the request vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; callers decide when the result is consumed.
// Ports: req (request levels), last_owner (search starts one past it),
//        excl (requesters masked out this cycle), valid (any candidate), winner (index).
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  input  logic [NUM_REQ-1:0] excl,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  logic [NUM_REQ-1:0] cand;
  logic [IDX_W-1:0]   idx;

  // Scan from the farthest offset down to the nearest so the last hit
  // written is the closest requester after last_owner; offset NUM_REQ
  // wraps back to last_owner itself, giving it the lowest priority.
  always_comb begin
    cand   = req & ~excl;
    valid  = 1'b0;
    winner = last_owner;
    idx    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = last_owner + IDX_W'(i);
      if (cand[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: 4-requester round-robin arbiter for a shared memory port with one-hot grant and mux select.
// Latency: grant one edge after req in IDLE; hand-over to the next winner on the release edge (no dead cycle).
// Backpressure: requesters hold req until acked; the grant holds until ack, owner abort or (optional) watchdog.
// Ports: clk, rst_n (async active-low), req[3:0], ack (owner completion pulse),
//        gnt[3:0] (one-hot, registered), sel[1:0] (owner index, holds while idle),
//        busy (grant open), timeout_err (one-cycle pulse on forced release).
// Build option: define ARB_TIMEOUT_EN to compile in the grant watchdog (TIMEOUT_CYCLES).
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ack,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   sel,
  output logic               busy,
  output logic               timeout_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be within 2..255");
  end

  state_t             state;
  logic [IDX_W-1:0]   last_owner;
  logic [IDX_W-1:0]   pick_base;
  logic [NUM_REQ-1:0] pick_excl;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic               expire;
  logic               release_now;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt;

  // Watchdog fires only when nothing else would release the grant this
  // edge, so ack and abort never raise an error.
  assign expire = (state == OWNED) && !ack && req[sel] && (cnt == TO_LAST);
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // While owned, the search base is the current owner and its own req is
  // masked, which is exactly the view needed on the release edge.
  always_comb begin
    pick_base = last_owner;
    pick_excl = '0;
    if (state == OWNED) begin
      pick_base = sel;
      pick_excl = gnt;
    end
  end

  assign release_now = (state == OWNED) && (ack || !req[sel] || expire);

  rr_pick u_rr_pick (
    .req        (req),
    .last_owner (pick_base),
    .excl       (pick_excl),
    .valid      (pick_vld),
    .winner     (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      sel         <= '0;
      busy        <= 1'b0;
      last_owner  <= IDX_W'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
      cnt         <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state <= OWNED;
            gnt   <= idx2onehot(pick_idx);
            sel   <= pick_idx;
            busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        OWNED: begin
          if (release_now) begin
            last_owner <= sel;
`ifdef ARB_TIMEOUT_EN
            timeout_err <= expire;
            cnt         <= '0;
`endif
            if (pick_vld) begin
              gnt <= idx2onehot(pick_idx);
              sel <= pick_idx;
            end else begin
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
            end
          end else begin
`ifdef ARB_TIMEOUT_EN
            cnt <= cnt + 8'd1;
`endif
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed self-checking bench for mem_port_arbiter.
// Latency: checks are sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_mem_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       ack;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .ack         (ack),
    .gnt         (gnt),
    .sel         (sel),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic b, input logic te);
    chk({tag, ".gnt"}, gnt, g);
    chk({tag, ".sel"}, {2'b00, sel}, {2'b00, s});
    chk({tag, ".busy"}, {3'b000, busy}, {3'b000, b});
    chk({tag, ".terr"}, {3'b000, timeout_err}, {3'b000, te});
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    ack   = 1'b0;
    #3;
    chk_grant("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_grant("idle_after_reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Two requesters: 0 wins first, ack hands straight to 2.
    req = 4'b0101;
    step();
    chk_grant("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    ack = 1'b1;
    step();
    chk_grant("handover_0_to_2", 4'b0100, 2'd2, 1'b1, 1'b0);
    ack = 1'b0;
    req = 4'b0100;
    step();
    chk_grant("hold_owner_2", 4'b0100, 2'd2, 1'b1, 1'b0);
    ack = 1'b1;
    step();
    chk_grant("release_to_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    req = 4'b0000;
    step();
    chk_grant("ack_in_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    ack = 1'b0;

    // Owner 3, then asynchronous reset mid-grant.
    req = 4'b1000;
    step();
    chk_grant("grant_3", 4'b1000, 2'd3, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_grant("async_reset_mid_grant", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk_grant("regrant_3_after_reset", 4'b1000, 2'd3, 1'b1, 1'b0);
    ack = 1'b1;
    step();
    chk_grant("release_3", 4'b0000, 2'd3, 1'b0, 1'b0);
    ack = 1'b0;
    req = 4'b0000;
    step();

    // All four requesting, ack every second cycle: order 0,1,2,3,0 with no gaps.
    req = 4'b1111;
    step();
    chk_grant("rr_0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_grant("rr_hold", 4'b0001 << (k - 1), 2'(k - 1), 1'b1, 1'b0);
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk_grant("rr_next", 4'b0001 << (k % 4), 2'(k % 4), 1'b1, 1'b0);
    end

    // Owner 0 -> 2, then owner 2 aborts with req[3] high.
    req = 4'b0100;
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk_grant("to_owner_2", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b1000;
    step();
    chk_grant("abort_2_to_3", 4'b1000, 2'd3, 1'b1, 1'b0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    req = 4'b0000;
    chk_grant("idle_sel_holds", 4'b0000, 2'd3, 1'b0, 1'b0);

    // Owner 1; non-owner req changes must not disturb it; then watchdog.
    req = 4'b0010;
    step();
    chk_grant("grant_1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b1011;
    step();
    chk_grant("nonowner_change", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0110;
    step();
    chk_grant("owned_cycle_3", 4'b0010, 2'd1, 1'b1, 1'b0);
    step();
    chk_grant("owned_cycle_4", 4'b0010, 2'd1, 1'b1, 1'b0);
    step();
`ifdef ARB_TIMEOUT_EN
    chk_grant("timeout_release", 4'b0100, 2'd2, 1'b1, 1'b1);
    step();
    chk_grant("timeout_pulse_end", 4'b0100, 2'd2, 1'b1, 1'b0);
`else
    chk_grant("no_watchdog", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) step();
    chk_grant("no_watchdog_long", 4'b0010, 2'd1, 1'b1, 1'b0);
`endif

    // Owner drops req with nobody else asking: abort to idle, no error.
    req = 4'b0000;
    step();
    chk({"abort_idle", ".gnt"}, gnt, 4'b0000);
    chk({"abort_idle", ".busy"}, {3'b000, busy}, 4'b0000);
    chk({"abort_idle", ".terr"}, {3'b000, timeout_err}, 4'b0000);

    // Single requester 0 holding req across ack: one idle cycle, then regrant.
    req = 4'b0001;
    step();
    chk_grant("single_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk_grant("single_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk_grant("single_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
